ysyx_24080014_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24080014_mem_arbiter

Overview:
- Parametrised N-master to 1-slave memory arbiter with valid/ready request and response channels.
- Sits between the fetch unit, the load/store unit (and future masters such as a DMA or debug port) and the single memory/bus port of the multi-cycle core.
- Replaces the fixed single-master IF/mem handshake of the single-cycle core.
- Supports fixed-priority or round-robin arbitration, with one outstanding transaction at a time.

Parameters:
- NUM_M, 2: number of masters (2..8); master 0 is IFU by convention.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- RR_EN, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m_req_valid  in  NUM_M  per-master request valid
- m_req_ready  out  NUM_M  per-master request accepted
- m_req_addr  in  NUM_M*ADDR_W  flattened addresses, master i at [i*ADDR_W +: ADDR_W]
- m_req_wen  in  NUM_M  1 = write, 0 = read
- m_req_wdata  in  NUM_M*DATA_W  flattened write data
- m_req_wmask  in  NUM_M*(DATA_W/8)  flattened byte strobes
- m_resp_valid  out  NUM_M  response valid, one-hot to the granted master
- m_resp_ready  in  NUM_M  per-master response ready
- m_resp_rdata  out  DATA_W  read data, shared by all masters
- m_resp_err  out  1  error flag, shared by all masters
- s_req_valid  out  1  slave request valid
- s_req_ready  in  1  slave accepts request
- s_req_addr  out  ADDR_W  slave address
- s_req_wen  out  1  slave write enable
- s_req_wdata  out  DATA_W  slave write data
- s_req_wmask  out  DATA_W/8  slave byte strobes
- s_resp_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter ready for slave response
- s_resp_rdata  in  DATA_W  slave read data
- s_resp_err  in  1  slave error
- grant_id  out  clog2(NUM_M), minimum 1  index of the current owner, for debug/perf

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - All valid/ready outputs = 0; grant_id = 0.
  - Request and response registers cleared to 0.
  - Round-robin pointer = 0.
- FSM states: IDLE, SREQ, SRESP.
- IDLE:
  - If any m_req_valid is set, pick winner W.
  - Fixed priority: W is the lowest set index.
  - Round-robin: W is the first set index at or after the pointer, wrapping modulo NUM_M.
  - In the same cycle, pulse m_req_ready[W] = 1 combinationally. The master's handshake completes.
  - Latch the winner's addr/wen/wdata/wmask and set grant_id = W.
  - Next state = SREQ.
  - m_req_ready is 0 for all masters in every other state/cycle.
- SREQ:
  - s_req_valid = 1, driven from the latched registers, held stable until s_req_ready.
  - On s_req_valid & s_req_ready, go to SRESP.
- SRESP:
  - s_resp_ready = m_resp_ready[grant_id].
  - m_resp_valid[grant_id] = s_resp_valid, passed through combinationally.
  - m_resp_rdata/err = s_resp_rdata/err.
  - On s_resp_valid & s_resp_ready:
    - If RR_EN, pointer = (grant_id+1) mod NUM_M.
    - Next state = IDLE.
- Latency:
  - Minimum 3 cycles from request accept to response when the slave responds with zero wait.
  - Back-to-back throughput is one transaction per 3 cycles; no request pipelining.
- Boundary conditions:
  - Masters not granted see m_req_ready = 0 and must hold their request.
  - A master dropping m_req_valid before grant is legal and is simply ignored.
  - s_resp_valid arriving while in IDLE or SREQ is a protocol violation. It is ignored, and s_resp_ready stays 0.
  - A request and a response in the same cycle cannot be accepted: a new grant is issued only from IDLE.
  - The round-robin pointer wraps from NUM_M-1 to 0.
  - Fixed priority may starve higher indices. This is documented, not prevented.
  - Reset asserted mid-transaction aborts to IDLE immediately. There is no response to the master, and the slave must also be reset.
  - For NUM_M = 1, the arbiter degenerates to a register slice with the same FSM.

Decomposition:
- Shared package/include ysyx_24080014_defs:
  - FSM state encodings ARB_IDLE = 2'd0, ARB_SREQ = 2'd1, ARB_SRESP = 2'd2.
  - Handshake width constants.
- One sub-module: ysyx_24080014_rr_pick. Purely combinational, parameter N. Inputs: req vector, pointer, mode. Output: one-hot grant plus index. Reused for fixed mode with pointer = 0.

Test Plan:
- Single master, NUM_M = 2: m0 reads 0x8000_0000; slave returns 0xDEAD_BEEF after 2 wait cycles -> m_req_ready[0] pulses in cycle 0, s_req_addr = 0x8000_0000, m_resp_valid[0] with rdata 0xDEAD_BEEF, grant_id = 0.
- Contention with RR_EN = 0: m0 and m1 both assert every cycle for 4 transactions -> all four granted to m0, m1 never granted.
- Contention with RR_EN = 1, NUM_M = 4, all requesting -> grant order 0, 1, 2, 3, 0; pointer wraps correctly.
- Write path: m1 writes wdata 0x1234_5678, wmask 4'b0011 to 0x8000_0010; slave stalls s_req_ready for 3 cycles -> s_req fields stay stable during the stall; the handshake completes once; s_resp_err = 1 is forwarded on m_resp_err.
- Response backpressure: m_resp_ready[1] held low for 5 cycles -> s_resp_ready = 0 during that time; the transaction completes on the first cycle m_resp_ready is high; state returns to IDLE.
- Reset mid-SREQ: rst driven low asynchronously between clock edges -> s_req_valid = 0 immediately, state = IDLE, grant_id = 0; the next request after rst rises is serviced normally.

Source files
------------

// File: rtl/ysyx_24080014_defs.sv
// Shared definitions for the memory arbiter: FSM encodings and width helpers.
package ysyx_24080014_defs;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_SREQ  = 2'd1;
    localparam arb_state_t ARB_SRESP = 2'd2;

    localparam int unsigned BYTE_W = 8;

    // Index width for n masters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_24080014_rr_pick.sv
// Combinational picker: first requester at or after ptr (mode=1), or lowest index (mode=0).
module ysyx_24080014_rr_pick
    import ysyx_24080014_defs::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;
    int unsigned   base;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        base  = mode ? 32'(ptr) : 32'd0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((base + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// N-master to 1-slave memory arbiter, one outstanding transaction, fixed or round-robin.
module ysyx_24080014_mem_arbiter
    import ysyx_24080014_defs::*;
#(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = 1'b0,
    localparam int unsigned IW    = idx_width(NUM_M),
    localparam int unsigned MW    = DATA_W / BYTE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]        m_req_valid,
    output logic [NUM_M-1:0]        m_req_ready,
    input  logic [NUM_M*ADDR_W-1:0] m_req_addr,
    input  logic [NUM_M-1:0]        m_req_wen,
    input  logic [NUM_M*DATA_W-1:0] m_req_wdata,
    input  logic [NUM_M*MW-1:0]     m_req_wmask,
    output logic [NUM_M-1:0]        m_resp_valid,
    input  logic [NUM_M-1:0]        m_resp_ready,
    output logic [DATA_W-1:0]       m_resp_rdata,
    output logic                    m_resp_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [MW-1:0]       s_req_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_resp_rdata,
    input  logic                s_resp_err,
    output logic [IW-1:0]       grant_id
);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]       wmask_q, wmask_d;

    logic [NUM_M-1:0]    pick_oh;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       ptr_next;
    logic                resp_fire;

    ysyx_24080014_rr_pick #(
        .N  (NUM_M),
        .IW (IW)
    ) u_pick (
        .req   (m_req_valid),
        .ptr   (ptr_q),
        .mode  (RR_EN),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    assign ptr_next  = (grant_q == IW'(NUM_M - 1)) ? '0 : grant_q + IW'(1);
    assign resp_fire = s_resp_valid && s_resp_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|m_req_valid) begin
                    state_d = ARB_SREQ;
                    grant_d = pick_idx;
                    addr_d  = m_req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wen_d   = m_req_wen[pick_idx];
                    wdata_d = m_req_wdata[pick_idx*DATA_W +: DATA_W];
                    wmask_d = m_req_wmask[pick_idx*MW +: MW];
                end
            end
            ARB_SREQ: begin
                if (s_req_ready) state_d = ARB_SRESP;
            end
            ARB_SRESP: begin
                if (resp_fire) begin
                    state_d = ARB_IDLE;
                    if (RR_EN) ptr_d = ptr_next;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        // Gated by rst so no master sees an accept while reset is held.
        m_req_ready  = (rst && state_q == ARB_IDLE) ? pick_oh : '0;
        s_req_valid  = (state_q == ARB_SREQ);
        s_req_addr   = addr_q;
        s_req_wen    = wen_q;
        s_req_wdata  = wdata_q;
        s_req_wmask  = wmask_q;
        m_resp_valid = '0;
        s_resp_ready = 1'b0;
        m_resp_rdata = '0;
        m_resp_err   = 1'b0;
        if (state_q == ARB_SRESP) begin
            s_resp_ready          = m_resp_ready[grant_q];
            m_resp_valid[grant_q] = s_resp_valid;
            m_resp_rdata          = s_resp_rdata;
            m_resp_err            = s_resp_err;
        end
        grant_id = grant_q;
    end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Scoreboard bench: random masters and slave around a 4-master round-robin arbiter,
// plus a 2-master fixed-priority instance for starvation and throughput.
module tb_ysyx_24080014_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req_valid, m_req_ready, m_req_wen, m_resp_valid, m_resp_ready;
    logic [N*AW-1:0] m_req_addr;
    logic [N*DW-1:0] m_req_wdata;
    logic [N*MW-1:0] m_req_wmask;
    logic [DW-1:0]   m_resp_rdata;
    logic            m_resp_err;
    logic            s_req_valid, s_req_ready, s_req_wen;
    logic [AW-1:0]   s_req_addr;
    logic [DW-1:0]   s_req_wdata, s_resp_rdata;
    logic [MW-1:0]   s_req_wmask;
    logic            s_resp_valid, s_resp_ready, s_resp_err;
    logic [1:0]      grant_id;

    ysyx_24080014_mem_arbiter #(
        .NUM_M (N), .ADDR_W (AW), .DATA_W (DW), .RR_EN (1'b1)
    ) dut (
        .clk (clk), .rst (rst),
        .m_req_valid (m_req_valid), .m_req_ready (m_req_ready), .m_req_addr (m_req_addr),
        .m_req_wen (m_req_wen), .m_req_wdata (m_req_wdata), .m_req_wmask (m_req_wmask),
        .m_resp_valid (m_resp_valid), .m_resp_ready (m_resp_ready),
        .m_resp_rdata (m_resp_rdata), .m_resp_err (m_resp_err),
        .s_req_valid (s_req_valid), .s_req_ready (s_req_ready), .s_req_addr (s_req_addr),
        .s_req_wen (s_req_wen), .s_req_wdata (s_req_wdata), .s_req_wmask (s_req_wmask),
        .s_resp_valid (s_resp_valid), .s_resp_ready (s_resp_ready),
        .s_resp_rdata (s_resp_rdata), .s_resp_err (s_resp_err),
        .grant_id (grant_id)
    );

    // Fixed-priority instance: both masters always request, slave never stalls.
    logic        b_en = 1'b0;
    logic [1:0]  b_req_valid, b_req_ready, b_resp_valid;
    logic [63:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic [7:0]  b_req_wmask;
    logic [31:0] b_resp_rdata, b_s_req_addr, b_s_req_wdata;
    logic        b_resp_err, b_s_req_valid, b_s_req_wen, b_s_resp_ready;
    logic [3:0]  b_s_req_wmask;
    logic [0:0]  b_grant_id;

    assign b_req_valid = b_en ? 2'b11 : 2'b00;
    assign b_req_addr  = {32'h8000_0010, 32'h8000_0000};
    assign b_req_wdata = {32'h2222_2222, 32'h1111_1111};
    assign b_req_wmask = 8'hff;

    ysyx_24080014_mem_arbiter #(
        .NUM_M (2), .ADDR_W (32), .DATA_W (32), .RR_EN (1'b0)
    ) dut_b (
        .clk (clk), .rst (rst),
        .m_req_valid (b_req_valid), .m_req_ready (b_req_ready), .m_req_addr (b_req_addr),
        .m_req_wen (2'b00), .m_req_wdata (b_req_wdata), .m_req_wmask (b_req_wmask),
        .m_resp_valid (b_resp_valid), .m_resp_ready (2'b11),
        .m_resp_rdata (b_resp_rdata), .m_resp_err (b_resp_err),
        .s_req_valid (b_s_req_valid), .s_req_ready (1'b1), .s_req_addr (b_s_req_addr),
        .s_req_wen (b_s_req_wen), .s_req_wdata (b_s_req_wdata), .s_req_wmask (b_s_req_wmask),
        .s_resp_valid (1'b1), .s_resp_ready (b_s_resp_ready),
        .s_resp_rdata (32'hDEAD_BEEF), .s_resp_err (1'b0),
        .grant_id (b_grant_id)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: transactions serialize in grant order against a word memory.
    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } req_t;
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    req_t          req_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] ref_mem [8];
    int unsigned   mptr = 0;
    int unsigned   owner = 0;
    bit            outstanding = 1'b0;
    bit            resp_pending = 1'b0;
    int            busy = 0;
    int            ndone = 0;
    bit            gen_en = 1'b0;
    bit            slave_stall = 1'b0;

    function automatic logic [DW-1:0] mem_init(input int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    function automatic int unsigned rr_winner(input logic [N-1:0] v, input int unsigned p);
        for (int unsigned off = 0; off < N; off++)
            if (v[(p + off) % N]) return (p + off) % N;
        return N;
    endfunction

    task automatic monitor_cycle();
        bit            os, rp;
        int unsigned   w, k;
        logic [N-1:0]  want_rdy, want_rv;
        logic          want_srr;
        req_t          r;
        rsp_t          p;
        os = outstanding;
        rp = resp_pending;

        w = rr_winner(m_req_valid, mptr);
        want_rdy = '0;
        if (!os && w < N) want_rdy[w] = 1'b1;
        chk("m_req_ready", m_req_ready, want_rdy);
        if (!os && w < N) begin
            r.addr  = m_req_addr[w*AW +: AW];
            r.wen   = m_req_wen[w];
            r.wdata = m_req_wdata[w*DW +: DW];
            r.wmask = m_req_wmask[w*MW +: MW];
            req_q.push_back(r);
            owner = w;
            outstanding = 1'b1;
            busy = 0;
        end

        chk("s_req_valid", s_req_valid, os && !rp);
        if (os) chk("grant_id", grant_id, owner);
        if (os && !rp && s_req_valid) begin
            r = req_q[0];
            chk("s_req_addr", s_req_addr, r.addr);
            chk("s_req_wen", s_req_wen, r.wen);
            chk("s_req_wdata", s_req_wdata, r.wdata);
            chk("s_req_wmask", s_req_wmask, r.wmask);
            if (s_req_ready) begin
                void'(req_q.pop_front());
                k = (r.addr - BASE) >> 2;
                p.rdata = r.wen ? '0 : ref_mem[k];
                p.err   = (k == 7);
                if (r.wen)
                    for (int b = 0; b < MW; b++)
                        if (r.wmask[b]) ref_mem[k][8*b +: 8] = r.wdata[8*b +: 8];
                rsp_q.push_back(p);
                resp_pending = 1'b1;
            end
        end

        want_rv  = '0;
        want_srr = 1'b0;
        if (rp) begin
            want_rv[owner] = s_resp_valid;
            want_srr       = m_resp_ready[owner];
        end
        chk("m_resp_valid", m_resp_valid, want_rv);
        chk("s_resp_ready", s_resp_ready, want_srr);
        if (rp && s_resp_valid && m_resp_ready[owner]) begin
            p = rsp_q.pop_front();
            chk("m_resp_rdata", m_resp_rdata, p.rdata);
            chk("m_resp_err", m_resp_err, p.err);
            outstanding  = 1'b0;
            resp_pending = 1'b0;
            mptr = (owner + 1) % N;
            ndone++;
        end

        if (os) begin
            busy++;
            if (busy > 200) begin
                chk("txn_timeout", 1, 0);
                req_q.delete();
                rsp_q.delete();
                outstanding  = 1'b0;
                resp_pending = 1'b0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) ref_mem[k] = mem_init(k);
        forever begin
            @(negedge clk);
            #4;
            if (rst) monitor_cycle();
        end
    end

    // Masters: hold a request until accepted, occasionally withdraw it before grant.
    initial begin
        logic [N-1:0] pend;
        logic [N-1:0] acc;
        pend = '0;
        acc  = '0;
        m_req_valid = '0; m_req_wen = '0; m_req_addr = '0;
        m_req_wdata = '0; m_req_wmask = '0; m_resp_ready = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (acc[i] || (pend[i] && $urandom_range(0, 15) == 0)) pend[i] = 1'b0;
                if (!pend[i] && gen_en && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    m_req_addr[i*AW +: AW]  = BASE + 32'($urandom_range(0, 7) * 4);
                    m_req_wen[i]            = 1'($urandom_range(0, 1));
                    m_req_wdata[i*DW +: DW] = $urandom;
                    m_req_wmask[i*MW +: MW] = 4'($urandom_range(1, 15));
                end
                m_req_valid[i]  = pend[i];
                m_resp_ready[i] = ($urandom_range(0, 2) != 0);
            end
            #4;
            acc = m_req_valid & m_req_ready;
        end
    end

    // Slave: random accept stalls, random response delay, stray responses while idle.
    initial begin
        logic [DW-1:0] smem [8];
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] wd;
        logic [MW-1:0] wm;
        int unsigned   k, d, n;
        bit            got, done;
        for (int i = 0; i < 8; i++) smem[i] = mem_init(i);
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_rdata = '0; s_resp_err = 1'b0;
        a = '0; we = 1'b0; wd = '0; wm = '0;
        forever begin
            got = 1'b0;
            while (!got) begin
                @(negedge clk);
                s_req_ready  = !slave_stall && ($urandom_range(0, 2) != 0);
                s_resp_valid = ($urandom_range(0, 4) == 0);
                s_resp_rdata = $urandom;
                s_resp_err   = 1'($urandom_range(0, 1));
                #4;
                if (rst && s_req_valid && s_req_ready) begin
                    got = 1'b1;
                    a = s_req_addr; we = s_req_wen; wd = s_req_wdata; wm = s_req_wmask;
                end
            end
            d = $urandom_range(0, 2);
            @(negedge clk);
            s_req_ready  = 1'b0;
            s_resp_valid = 1'b0;
            repeat (d) @(negedge clk);
            k = ((a - BASE) >> 2) & 7;
            s_resp_rdata = we ? '0 : smem[k];
            s_resp_err   = (k == 7);
            if (we)
                for (int b = 0; b < MW; b++)
                    if (wm[b]) smem[k][8*b +: 8] = wd[8*b +: 8];
            s_resp_valid = 1'b1;
            done = 1'b0;
            n = 0;
            while (!done && n < 300) begin
                #4;
                if (s_resp_ready) done = 1'b1;
                n++;
                if (!done) @(negedge clk);
            end
        end
    end

    initial begin
        bit found;
        int d0, g0, g1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_req_ready", m_req_ready, 0);
        chk("rst_s_req_valid", s_req_valid, 0);
        chk("rst_m_resp_valid", m_resp_valid, 0);
        chk("rst_s_resp_ready", s_resp_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_b_s_req_valid", b_s_req_valid, 0);

        @(negedge clk);
        rst = 1'b1;
        gen_en = 1'b1;
        repeat (1500) @(negedge clk);
        chk("enough_txns", ndone > 50, 1);

        // Abort a transaction while it waits in SREQ.
        slave_stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (s_req_valid) found = 1'b1;
        end
        chk("reached_sreq", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_s_req_valid", s_req_valid, 0);
        chk("abort_grant_id", grant_id, 0);
        chk("abort_m_req_ready", m_req_ready, 0);
        chk("abort_m_resp_valid", m_resp_valid, 0);
        req_q.delete();
        rsp_q.delete();
        outstanding  = 1'b0;
        resp_pending = 1'b0;
        mptr = 0;
        busy = 0;
        @(negedge clk);
        rst = 1'b1;
        slave_stall = 1'b0;
        d0 = ndone;
        repeat (300) @(negedge clk);
        chk("txns_after_reset", ndone > d0, 1);

        gen_en = 1'b0;
        for (int i = 0; i < 400 && (outstanding || m_req_valid != 0); i++) @(negedge clk);
        chk("drained", outstanding, 0);
        chk("queues_empty", req_q.size() + rsp_q.size(), 0);

        // Fixed priority: master 1 starves, one transaction per three cycles.
        @(negedge clk);
        b_en = 1'b1;
        g0 = 0;
        g1 = 0;
        repeat (12) begin
            #4;
            if (b_req_ready[0]) begin
                g0++;
                chk("b_s_resp_ready_idle", b_s_resp_ready, 0);
            end
            if (b_req_ready[1]) g1++;
            if (b_s_req_valid) chk("b_s_req_addr", b_s_req_addr, 32'h8000_0000);
            if (b_resp_valid != 0) begin
                chk("b_m_resp_valid", b_resp_valid, 2'b01);
                chk("b_m_resp_rdata", b_resp_rdata, 32'hDEAD_BEEF);
            end
            @(negedge clk);
        end
        chk("b_grants_m0", g0, 4);
        chk("b_grants_m1", g1, 0);
        chk("b_grant_id", b_grant_id, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
